// File: rtl/run_step_ctrl.sv
// run_step_ctrl: run/step/halt clock-enable controller for the accumulator CPU
module run_step_ctrl #(
    parameter int T_STATES = 6,
    parameter int PC_W     = 4
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            run_req,
    input  logic            step_btn,
    input  logic            step_mode,
    input  logic            hlt_req,
    input  logic [2:0]      t_state,
    input  logic [PC_W-1:0] pc,
    input  logic            bp_en,
    input  logic [PC_W-1:0] bp_addr,
    output logic            cpu_ce,
    output logic [1:0]      state,
    output logic            halted,
    output logic            bp_hit,
    output logic [15:0]     cycle_cnt
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2,
        HALT = 2'd3
    } state_t;

    localparam logic [2:0] T_LAST = 3'(T_STATES - 1);

    state_t      state_q, state_d;
    logic        s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic        run_q, run_d;
    logic        mode_q, mode_d;
    logic        bp_hit_q, bp_hit_d;
    logic [15:0] cnt_q, cnt_d;
    logic        step_pulse, run_rise, last, bp_match;

    assign step_pulse = s2_q & ~s3_q;
    assign run_rise   = run_req & ~run_q;
    assign last       = (t_state == T_LAST);
    assign bp_match   = bp_en & last & (pc == bp_addr);

    assign cpu_ce    = (state_q == RUN) || (state_q == STEP);
    assign state     = state_q;
    assign halted    = (state_q == HALT);
    assign bp_hit    = bp_hit_q;
    assign cycle_cnt = cnt_q;

    // Next-state logic: synchronizer shift, run edge capture, FSM and saturating cycle counter
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        bp_hit_d = bp_hit_q;
        s1_d     = step_btn;
        s2_d     = s1_q;
        s3_d     = s2_q;
        run_d    = run_req;
        cnt_d    = (cpu_ce && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
        case (state_q)
            IDLE: begin
                if (run_rise) begin
                    state_d  = RUN;
                    bp_hit_d = 1'b0;
                end else if (step_pulse) begin
                    state_d  = STEP;
                    mode_d   = step_mode;
                    bp_hit_d = 1'b0;
                end
            end
            RUN: begin
                if (hlt_req) begin
                    state_d = HALT;
                end else if (bp_match) begin
                    state_d  = IDLE;
                    bp_hit_d = 1'b1;
                end else if (!run_req && last) begin
                    state_d = IDLE;
                end
            end
            STEP: begin
                if (hlt_req) begin
                    state_d = HALT;
                end else if (!mode_q || last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = HALT;
        endcase
    end

    // State registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q  <= IDLE;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            s3_q     <= 1'b0;
            run_q    <= 1'b0;
            mode_q   <= 1'b0;
            bp_hit_q <= 1'b0;
            cnt_q    <= 16'd0;
        end else begin
            state_q  <= state_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            s3_q     <= s3_d;
            run_q    <= run_d;
            mode_q   <= mode_d;
            bp_hit_q <= bp_hit_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: tb/tb_run_step_ctrl.sv
// tb_run_step_ctrl: randomized check of run_step_ctrl against a behavioural model
module tb_run_step_ctrl;
    localparam int T = 6;
    localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_HALT = 3;

    logic        clk = 1'b0;
    logic        clr, run_req, step_btn, step_mode, hlt_req, bp_en;
    logic [2:0]  t_state;
    logic [3:0]  pc, bp_addr;
    logic        cpu_ce, halted, bp_hit;
    logic [1:0]  state;
    logic [15:0] cycle_cnt;

    int n_chk = 0, n_fail = 0;

    int          m_st, m_left, t;
    bit          m_bp, m_runq;
    bit  [2:0]   sh;
    logic [15:0] m_cnt;
    int          btn_hold = 0, halt_cnt = 0;

    run_step_ctrl #(.T_STATES(T), .PC_W(4)) dut (
        .clk(clk), .clr(clr), .run_req(run_req), .step_btn(step_btn),
        .step_mode(step_mode), .hlt_req(hlt_req), .t_state(t_state), .pc(pc),
        .bp_en(bp_en), .bp_addr(bp_addr), .cpu_ce(cpu_ce), .state(state),
        .halted(halted), .bp_hit(bp_hit), .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: the CPU is enabled while running or stepping; a step has a cycle budget fixed at entry
    task automatic model_edge();
        bit pulse, rise, ce, lst;
        int nst;
        pulse = sh[1] & ~sh[2];
        rise  = run_req & ~m_runq;
        ce    = (m_st == M_RUN) || (m_st == M_STEP);
        lst   = (t == T - 1);
        nst   = m_st;
        if (ce && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        if (m_st == M_IDLE) begin
            if (rise) begin
                nst = M_RUN; m_bp = 0;
            end else if (pulse) begin
                nst = M_STEP; m_bp = 0; m_left = step_mode ? T - t : 1;
            end
        end else if (m_st == M_RUN) begin
            if (hlt_req) nst = M_HALT;
            else if (bp_en && lst && pc == bp_addr) begin nst = M_IDLE; m_bp = 1; end
            else if (!run_req && lst) nst = M_IDLE;
        end else if (m_st == M_STEP) begin
            if (hlt_req) nst = M_HALT;
            else begin
                m_left--;
                if (m_left == 0) nst = M_IDLE;
            end
        end
        if (ce) t = lst ? 0 : t + 1;
        sh     = {sh[1:0], step_btn};
        m_runq = run_req;
        m_st   = nst;
    endtask

    always @(posedge clk or negedge clr) begin
        if (!clr) begin
            m_st = M_IDLE; m_cnt = 16'd0; m_bp = 0; sh = 3'b0; m_runq = 0; m_left = 0; t = 0;
        end else begin
            model_edge();
        end
    end

    task automatic compare_all();
        check("state", 32'(state), 32'(m_st));
        check("cpu_ce", 32'(cpu_ce), 32'(m_st == M_RUN || m_st == M_STEP));
        check("halted", 32'(halted), 32'(m_st == M_HALT));
        check("bp_hit", 32'(bp_hit), 32'(m_bp));
        check("cycle_cnt", 32'(cycle_cnt), 32'(m_cnt));
    endtask

    task automatic async_reset();
        #1 clr = 1'b0;
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_cpu_ce", 32'(cpu_ce), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_bp_hit", 32'(bp_hit), 32'd0);
        check("rst_cycle_cnt", 32'(cycle_cnt), 32'd0);
        clr = 1'b1;
        run_req = 1'b0; step_btn = 1'b0; hlt_req = 1'b0; btn_hold = 0;
    endtask

    task automatic drive_random();
        if (btn_hold > 0) btn_hold--;
        else if ($urandom_range(0, 7) == 0) btn_hold = $urandom_range(1, 6);
        step_btn  = (btn_hold > 0);
        if ($urandom_range(0, 9) == 0) run_req = ~run_req;
        step_mode = 1'($urandom_range(0, 1));
        hlt_req   = ($urandom_range(0, 199) == 0);
        bp_en     = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 15) == 0) bp_addr = 4'($urandom);
        pc = ($urandom_range(0, 2) == 0) ? bp_addr : 4'($urandom);
    endtask

    initial begin
        clr = 1'b0; run_req = 0; step_btn = 0; step_mode = 0; hlt_req = 0;
        bp_en = 0; bp_addr = 4'd4; pc = 0; t_state = 0;
        repeat (2) @(negedge clk);
        compare_all();
        clr = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            compare_all();
            halt_cnt = (m_st == M_HALT) ? halt_cnt + 1 : 0;
            if (halt_cnt > 6 || $urandom_range(0, 599) == 0) begin
                async_reset();
                halt_cnt = 0;
            end else begin
                drive_random();
            end
            t_state = 3'(t);
        end
        @(negedge clk);
        async_reset();
        bp_en = 0; step_mode = 0; t_state = 3'(t);
        @(negedge clk);
        compare_all();
        run_req = 1'b1;
        for (int i = 0; i < 65545; i++) begin
            @(negedge clk);
            compare_all();
            pc = 4'($urandom);
            t_state = 3'(t);
        end
        check("saturated", 32'(cycle_cnt), 32'hFFFF);
        bp_en = 1'b1; bp_addr = 4'd4; pc = 4'd4; hlt_req = 1'b1;
        @(negedge clk);
        compare_all();
        hlt_req = 1'b0;
        for (int i = 0; i < 30; i++) begin
            run_req  = 1'($urandom_range(0, 1));
            step_btn = 1'($urandom_range(0, 1));
            t_state  = 3'(t);
            @(negedge clk);
            compare_all();
        end
        check("halt_frozen_cnt", 32'(cycle_cnt), 32'hFFFF);
        check("halt_halted", 32'(halted), 32'd1);
        check("halt_no_bp", 32'(bp_hit), 32'd0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
